// File: rtl/prio_arb_pkg.sv
// Shared constants and helpers for the priority arbiter slice.
package prio_arb_pkg;

   // Arbitration mode selectors for the RR parameter
   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // Index width for n requesters: ceil(log2 n), never narrower than one bit
   function automatic int idx_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/prio_arb_if.sv
// Request/grant bundle between requesters, consumer and the arbiter.
interface prio_arb_if
   import prio_arb_pkg::*;
#(
   parameter int N = 8
);
   localparam int W = idx_width(N);

   logic [N-1:0] req;
   logic         grant_ready;
   logic         grant_valid;
   logic [W-1:0] grant_idx;
   logic [N-1:0] grant_onehot;

   // Requester/consumer side drives requests and readiness
   modport master (
      output req,
      output grant_ready,
      input  grant_valid,
      input  grant_idx,
      input  grant_onehot
   );

   // Arbiter side presents the registered grant
   modport slave (
      input  req,
      input  grant_ready,
      output grant_valid,
      output grant_idx,
      output grant_onehot
   );

endinterface

// File: rtl/prio_pick.sv
// Combinational highest-set-bit finder: reports the top set index and
// whether any bit was set at all.
module prio_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scan upward so the last (highest) set bit is the one that sticks
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_arbiter.sv
// Registered priority arbiter with fixed or round-robin selection.
// A grant is held under backpressure and replaced whenever the slot is
// empty or the consumer takes it.
module prio_arbiter
   import prio_arb_pkg::*;
#(
   parameter int N  = 8,
   parameter int RR = PRIO_FIXED
) (
   input  logic     clk,
   input  logic     rst_n,
   prio_arb_if.slave bus
);

   localparam int W = idx_width(N);

   logic [W-1:0] win_idx;
   logic         win_found;
   logic         load;
   logic         handshake;

   assign load      = !bus.grant_valid || bus.grant_ready;
   assign handshake = bus.grant_valid && bus.grant_ready;

   if (RR == PRIO_RR) begin : g_rr
      logic [W-1:0] ptr;
      logic [W-1:0] eff_ptr;
      logic [N-1:0] below;
      logic [N-1:0] masked;
      logic [W-1:0] masked_idx;
      logic         masked_found;
      logic [W-1:0] full_idx;
      logic         full_found;

      // A grant being taken this cycle becomes the new pointer right away,
      // so back-to-back grants rotate without an idle slot
      assign eff_ptr = handshake ? bus.grant_idx : ptr;

      // Indices strictly below the pointer are searched first
      always_comb begin
         below = '0;
         for (int i = 0; i < N; i++) begin
            below[i] = (W'(i) < eff_ptr);
         end
      end

      assign masked = bus.req & below;

      prio_pick #(.N(N), .W(W)) u_pick_masked (
         .vec   (masked),
         .idx   (masked_idx),
         .found (masked_found)
      );

      prio_pick #(.N(N), .W(W)) u_pick_full (
         .vec   (bus.req),
         .idx   (full_idx),
         .found (full_found)
      );

      // Wrap-around: fall back to the top of the unmasked vector, which
      // leaves the pointer position itself as the last choice
      assign win_idx   = masked_found ? masked_idx : full_idx;
      assign win_found = full_found;

      // Pointer follows each accepted grant; it only ever holds a granted
      // index, so it stays below N
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ptr <= '0;
         end else if (handshake) begin
            ptr <= bus.grant_idx;
         end
      end
   end else begin : g_fixed
      // Fixed priority keeps no pointer state: the order never rotates
      prio_pick #(.N(N), .W(W)) u_pick (
         .vec   (bus.req),
         .idx   (win_idx),
         .found (win_found)
      );
   end

   // Output stage: load a new winner when the slot is free or being taken,
   // otherwise hold everything regardless of the request vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.grant_valid  <= 1'b0;
         bus.grant_idx    <= '0;
         bus.grant_onehot <= '0;
      end else if (load) begin
         if (win_found) begin
            bus.grant_valid  <= 1'b1;
            bus.grant_idx    <= win_idx;
            bus.grant_onehot <= N'(1) << win_idx;
         end else begin
            bus.grant_valid  <= 1'b0;
            bus.grant_onehot <= '0;
         end
      end
   end

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: fixed N=8, round-robin N=8 and round-robin N=5
// instances share one stimulus stream and are checked against a
// search-order reference model plus hand-derived vectors.
module tb_prio_arbiter;
   import prio_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] stim_req;
   logic       stim_ready;

   int passed = 0;
   int total  = 0;

   int m_n  [3] = '{8, 8, 5};
   int m_rr [3] = '{0, 1, 1};
   int m_valid [3];
   int m_idx   [3];
   int m_ptr   [3];

   typedef struct {
      logic [7:0] req;
      logic       ready;
      int         exp_valid;
      int         exp_idx;
      int         exp_onehot;
   } vec_t;

   vec_t tbl [13];

   // Free-running clock
   always #5 clk = ~clk;

   prio_arb_if #(.N(8)) bus_fix ();
   prio_arb_if #(.N(8)) bus_rr ();
   prio_arb_if #(.N(5)) bus_rr5 ();

   assign bus_fix.req         = stim_req;
   assign bus_fix.grant_ready = stim_ready;
   assign bus_rr.req          = stim_req;
   assign bus_rr.grant_ready  = stim_ready;
   assign bus_rr5.req         = stim_req[4:0];
   assign bus_rr5.grant_ready = stim_ready;

   prio_arbiter #(.N(8), .RR(PRIO_FIXED)) u_fix (.clk(clk), .rst_n(rst_n), .bus(bus_fix));
   prio_arbiter #(.N(8), .RR(PRIO_RR))    u_rr  (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
   prio_arbiter #(.N(5), .RR(PRIO_RR))    u_rr5 (.clk(clk), .rst_n(rst_n), .bus(bus_rr5));

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Search order p-1, p-2, ..., wrapping modulo n; first set bit wins
   function automatic int searchWinner(input int r, input int n, input int p);
      for (int k = 1; k <= n; k++) begin
         int j;
         j = (((p - k) % n) + n) % n;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 3; d++) begin
         m_valid[d] = 0;
         m_idx[d]   = 0;
         m_ptr[d]   = 0;
      end
   endtask

   task automatic modelStep();
      for (int d = 0; d < 3; d++) begin
         int r;
         int p;
         bit ld;
         bit hs;
         r  = int'(stim_req) & ((1 << m_n[d]) - 1);
         ld = (m_valid[d] == 0) || stim_ready;
         hs = (m_valid[d] != 0) && stim_ready;
         if (m_rr[d] != 0 && hs) m_ptr[d] = m_idx[d];
         p = (m_rr[d] != 0) ? m_ptr[d] : 0;
         if (ld) begin
            if (r == 0) begin
               m_valid[d] = 0;
            end else begin
               m_valid[d] = 1;
               m_idx[d]   = searchWinner(r, m_n[d], p);
            end
         end
      end
   endtask

   task automatic getActual(input int d, output int v, output int i, output int oh);
      case (d)
         0: begin
            v = int'(bus_fix.grant_valid); i = int'(bus_fix.grant_idx); oh = int'(bus_fix.grant_onehot);
         end
         1: begin
            v = int'(bus_rr.grant_valid); i = int'(bus_rr.grant_idx); oh = int'(bus_rr.grant_onehot);
         end
         default: begin
            v = int'(bus_rr5.grant_valid); i = int'(bus_rr5.grant_idx); oh = int'(bus_rr5.grant_onehot);
         end
      endcase
   endtask

   task automatic applyStimulus(input logic [7:0] r, input logic rdy);
      stim_req   = r;
      stim_ready = rdy;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic checkOutput(input string tag);
      for (int d = 0; d < 3; d++) begin
         int v, i, oh, exp_oh;
         getActual(d, v, i, oh);
         exp_oh = (m_valid[d] != 0) ? (1 << m_idx[d]) : 0;
         check($sformatf("%s.dut%0d.valid", tag, d), v, m_valid[d]);
         check($sformatf("%s.dut%0d.idx", tag, d), i, m_idx[d]);
         check($sformatf("%s.dut%0d.onehot", tag, d), oh, exp_oh);
      end
   endtask

   // Asserts reset between edges, checks the outputs clear without a clock,
   // then releases on a falling edge followed by one idle cycle
   task automatic doReset(input string tag);
      rst_n = 1'b0;
      #2;
      modelReset();
      checkOutput(tag);
      stim_req   = 8'h00;
      stim_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   int exp_rr8 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
   int exp_rr5 [9] = '{4, 3, 2, 1, 0, 4, 3, 2, 1};
   int exp_sp  [4] = '{3, 0, 3, 0};

   initial begin
      int v, i, oh;
      rst_n      = 1'b0;
      stim_req   = 8'h00;
      stim_ready = 1'b0;
      modelReset();
      #3;
      doReset("reset_init");

      // Fixed-priority vectors for the N=8 fixed instance
      tbl[0]  = '{8'b0010_0110, 1'b1, 1, 5, 8'h20};
      tbl[1]  = '{8'h80,        1'b0, 1, 5, 8'h20};
      tbl[2]  = '{8'h80,        1'b0, 1, 5, 8'h20};
      tbl[3]  = '{8'h80,        1'b0, 1, 5, 8'h20};
      tbl[4]  = '{8'h80,        1'b1, 1, 7, 8'h80};
      tbl[5]  = '{8'h00,        1'b1, 0, 7, 8'h00};
      tbl[6]  = '{8'h00,        1'b0, 0, 7, 8'h00};
      tbl[7]  = '{8'h01,        1'b0, 1, 0, 8'h01};
      tbl[8]  = '{8'h03,        1'b0, 1, 0, 8'h01};
      tbl[9]  = '{8'h03,        1'b1, 1, 1, 8'h02};
      tbl[10] = '{8'h0F,        1'b1, 1, 3, 8'h08};
      tbl[11] = '{8'h04,        1'b1, 1, 2, 8'h04};
      tbl[12] = '{8'h00,        1'b1, 0, 2, 8'h00};

      for (int k = 0; k < 13; k++) begin
         applyStimulus(tbl[k].req, tbl[k].ready);
         checkOutput($sformatf("tbl%0d", k));
         getActual(0, v, i, oh);
         check($sformatf("tbl%0d.fixed.valid", k), v, tbl[k].exp_valid);
         check($sformatf("tbl%0d.fixed.idx", k), i, tbl[k].exp_idx);
         check($sformatf("tbl%0d.fixed.onehot", k), oh, tbl[k].exp_onehot);
      end

      // Reset arriving while a grant is presented discards it
      applyStimulus(8'hFF, 1'b0);
      getActual(0, v, i, oh);
      check("pre_reset.fixed.valid", v, 1);
      #2;
      doReset("reset_mid_grant");

      // Round-robin full load rotates one index per cycle with no bubble
      for (int k = 0; k < 9; k++) begin
         applyStimulus(8'hFF, 1'b1);
         checkOutput($sformatf("rr_full%0d", k));
         getActual(1, v, i, oh);
         check($sformatf("rr_full%0d.rr8.idx", k), i, exp_rr8[k]);
         getActual(2, v, i, oh);
         check($sformatf("rr_full%0d.rr5.idx", k), i, exp_rr5[k]);
      end

      // Sparse round-robin alternates between the two requesters
      doReset("reset_sparse");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'b0000_1001, 1'b1);
         checkOutput($sformatf("rr_sparse%0d", k));
         getActual(1, v, i, oh);
         check($sformatf("rr_sparse%0d.rr8.idx", k), i, exp_sp[k]);
         getActual(2, v, i, oh);
         check($sformatf("rr_sparse%0d.rr5.idx", k), i, exp_sp[k]);
      end
      applyStimulus(8'h00, 1'b1);
      checkOutput("rr_sparse_idle");
      getActual(1, v, i, oh);
      check("rr_sparse_idle.rr8.valid", v, 0);
      check("rr_sparse_idle.rr8.idx", i, 0);

      // A lone requester is granted repeatedly in every mode
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'h04, 1'b1);
         checkOutput($sformatf("single%0d", k));
         getActual(1, v, i, oh);
         check($sformatf("single%0d.rr8.idx", k), i, 2);
         getActual(2, v, i, oh);
         check($sformatf("single%0d.rr5.idx", k), i, 2);
      end

      // Randomised traffic against the reference model
      for (int k = 0; k < 600; k++) begin
         logic [7:0] r;
         logic       rdy;
         case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'h01 << $urandom_range(0, 7);
            2:       r = 8'($urandom);
            default: r = 8'($urandom) & 8'($urandom);
         endcase
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) begin
            doReset($sformatf("rand_reset%0d", k));
         end
         applyStimulus(r, rdy);
         checkOutput($sformatf("rand%0d", k));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter N, default 8: number of request lines, legal range 2..32.
REQ-002 Parameter RR, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 Derived constant W = max(1, ceil(log2 N)): width of the index output; not overridable.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req  in  N  request vector; bit i = requester i; may change every cycle.
REQ-007 grant_ready  in  1  consumer accepts the presented grant this cycle.
REQ-008 grant_valid  out  1  registered; a grant is presented.
REQ-009 grant_idx  out  W  registered; index of the granted requester.
REQ-010 grant_onehot  out  N  registered; one-hot of grant_idx while grant_valid=1, all-zero otherwise.

Function
REQ-011 Load condition, evaluated each cycle: (!grant_valid || grant_ready).
REQ-012 If the load condition holds and |req=1: next cycle grant_valid=1, and grant_idx/grant_onehot take the winner of the current req.
REQ-013 If the load condition holds and req=0: next cycle grant_valid=0, grant_onehot=0, and grant_idx holds its previous value.
REQ-014 If grant_valid=1 and grant_ready=0: all outputs hold, whatever req does, including deassertion of the granted bit.
REQ-015 Latency: one cycle from req sampled to grant presented; throughput is one grant per cycle while grant_ready=1.
REQ-016 Fixed mode: the winner is the highest set index of req.
REQ-017 RR mode: internal pointer ptr (W bits). The search order is ptr-1, ptr-2, ..., 0, N-1, ..., ptr (mod N); the first set bit wins, so requester ptr has lowest priority.
REQ-018 RR mode: on a handshake (grant_valid && grant_ready), ptr <= grant_idx.
REQ-019 RR mode: the selection made in a handshake cycle uses the updated pointer (grant_idx), so back-to-back grants rotate without a bubble.
REQ-020 Fixed mode: ptr is held at 0, making the search order identical to REQ-016.
REQ-021 Width rule: winner search and pointer arithmetic wrap modulo N, including for non-power-of-two N. ptr never holds a value >= N.
REQ-022 Single requester: in either mode, a lone set bit k is granted every load cycle, giving k, k, k, ...
REQ-023 Outputs are driven only from registers; there is no combinational path from req or grant_ready to any output.

Reset
REQ-024 While rst_n=0, immediately and independent of clk: grant_valid=0, grant_idx=0, grant_onehot=0, ptr=0.
REQ-025 Reset asserted mid-grant discards the pending grant. The first grant after release follows the fixed-order search from ptr=0.
REQ-026 Reset deassertion is synchronised by the integrating level; the block requires only that release meets recovery timing to clk.

Structure
REQ-027 Package prio_arb_pkg holds the mode constants PRIO_FIXED=0 and PRIO_RR=1, and the index-width function used to derive W.
REQ-028 Sub-module prio_pick: a combinational N-bit "highest set bit" finder that outputs an index and a found flag.
REQ-029 In RR mode, prio_pick is instantiated twice, once on req masked to indices below ptr and once on unmasked req; the masked result is used when found. Fixed mode uses one instance.
REQ-030 The registered output stage and ptr live in prio_arbiter.

Verification (N=8)
REQ-031 Reset: assert rst_n=0 between clock edges -> grant_valid, grant_idx and grant_onehot go to 0 before the next edge.
REQ-032 Fixed priority: req=8'b0010_0110, grant_ready=1 -> one cycle later grant_idx=5, grant_onehot=8'b0010_0000, grant_valid=1.
REQ-033 Backpressure: grant idx 5 presented, grant_ready=0, req changed to 8'h80 for 3 cycles -> outputs stay at 5. Raise grant_ready -> next cycle grant_idx=7.
REQ-034 RR full load: RR=1, req=8'hFF, grant_ready=1 held -> grant_idx sequence 7,6,5,4,3,2,1,0,7, one per cycle with no bubbles.
REQ-035 RR sparse: RR=1, req=8'b0000_1001 -> sequence 3,0,3,0. Then req=0 -> grant_valid=0 and grant_idx holds 0.
REQ-036 Non-power-of-two: N=5, RR=1, req=5'b11111 -> sequence 4,3,2,1,0,4. ptr never exceeds 4.
